// File: rtl/addsub_serial_unit.sv
// -----------------------------------------------------------------------------
// addsub_serial_unit
//   Digit-serial adder/subtractor. DIGIT bits of a WIDTH-bit operation are
//   processed per clock, so one operation takes N = WIDTH/DIGIT RUN cycles
//   followed by a single DONE cycle (back-to-back starts are accepted in DONE).
//   Computes A + B + cin (op=0) or A + ~B + cin (op=1) and reports carry out,
//   signed overflow and zero.
//
//   Optional build macro: ADDSUB_SATURATE_EN
//     When defined, an overflowing result is clamped to the signed limit of
//     the true result's sign. zero follows the clamped value; cout and ovf do
//     not change. When undefined, the result wraps modulo 2^WIDTH.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous active-high reset
//   start   in   1      operation request, sampled while ready=1
//   op      in   1      0: add, 1: add with B inverted (subtract)
//   A, B    in   WIDTH  operands, latched on an accepted start
//   cin     in   1      carry in, latched on an accepted start
//   ready   out  1      high in IDLE and DONE
//   done    out  1      one-cycle pulse, outputs below are valid
//   Result  out  WIDTH  sum/difference, held until the next operation ends
//   cout    out  1      carry out of the MSB
//   ovf     out  1      signed overflow
//   zero    out  1      Result == 0
// -----------------------------------------------------------------------------
module addsub_serial_unit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [WIDTH-1:0] a_nxt, b_nxt, res_nxt, res_final;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   dsum;
    logic             c_into_msb;
    logic             ovf_nxt;
    logic             last;

    // One digit of the ripple add: low DIGIT bits of both shifters plus carry.
    assign dsum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry};

    // Carry into the top bit of this digit, recovered from sum = a ^ b ^ c.
    // On the final digit that top bit is the operand MSB.
    assign c_into_msb = dsum[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
    assign ovf_nxt    = c_into_msb ^ dsum[DIGIT];
    assign last       = (cnt == CW'(N - 1));

    // Operands shift right, sum digits enter Result from the MSB end, so after
    // N digits the first digit has arrived at bit 0.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign a_nxt   = '0;
            assign b_nxt   = '0;
            assign res_nxt = dsum[DIGIT-1:0];
        end else begin : g_multi
            assign a_nxt   = {{DIGIT{1'b0}}, a_sh[WIDTH-1:DIGIT]};
            assign b_nxt   = {{DIGIT{1'b0}}, b_sh[WIDTH-1:DIGIT]};
            assign res_nxt = {dsum[DIGIT-1:0], res_sh[WIDTH-1:DIGIT]};
        end
    endgenerate

`ifdef ADDSUB_SATURATE_EN
    // Operand MSBs after inversion; on overflow they are equal and give the
    // sign of the true result.
    logic a_msb, b_msb;

    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] val,
                                                  input logic             of,
                                                  input logic             pos);
        if (!of)
            return val;
        else if (pos)
            return {1'b0, {(WIDTH-1){1'b1}}};
        else
            return {1'b1, {(WIDTH-1){1'b0}}};
    endfunction

    assign res_final = saturate(res_nxt, ovf_nxt, ~a_msb & ~b_msb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (accept) begin
            a_msb <= A[WIDTH-1];
            b_msb <= op ? ~B[WIDTH-1] : B[WIDTH-1];
        end
    end
`else
    assign res_final = res_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b1;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                ready = 1'b0;
                if (last)
                    state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else if (accept) begin
            a_sh   <= A;
            b_sh   <= op ? ~B : B;
            res_sh <= '0;
            carry  <= cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_nxt;
            b_sh   <= b_nxt;
            res_sh <= res_nxt;
            carry  <= dsum[DIGIT];
            cnt    <= cnt + CW'(1);
            if (last) begin
                Result <= res_final;
                cout   <= dsum[DIGIT];
                ovf    <= ovf_nxt;
                zero   <= (res_final == '0);
            end
        end
    end

endmodule
